// File: rtl/sha1_round_sequencer.sv
// SHA-1 round sequencer: captures a 512-bit block, expands W[t] in a 16-word circular buffer
// and issues 80 rounds with K/f decode. Optional block counter: SHA1_SEQ_BLOCK_COUNT_EN.
module sha1_round_sequencer (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         first_block,
   input  logic         hold,
   input  logic [511:0] block_in,
   output logic         init_iv,
   output logic         round_en,
   output logic [6:0]   round_idx,
   output logic [31:0]  w_t,
   output logic [31:0]  k_t,
   output logic [1:0]   f_sel,
   output logic         accumulate,
   output logic         busy,
   output logic         done,
   output logic [1:0]   state,
   output logic [31:0]  block_count
);

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_LOAD   = 2'b01;
   localparam logic [1:0] ST_ROUND  = 2'b10;
   localparam logic [1:0] ST_FINISH = 2'b11;

   localparam logic [31:0] K0 = 32'h5A827999;
   localparam logic [31:0] K1 = 32'h6ED9EBA1;
   localparam logic [31:0] K2 = 32'h8F1BBCDC;
   localparam logic [31:0] K3 = 32'hCA62C1D6;

   logic [1:0]  r_state;
   logic [6:0]  r_round_idx;
   logic        r_first;
   logic [31:0] r_buf [0:15];

   logic [3:0]  w_idx;
   logic [3:0]  w_idx_m3;
   logic [3:0]  w_idx_m8;
   logic [3:0]  w_idx_m14;
   logic [31:0] w_mix;
   logic [31:0] w_wt;
   logic        w_round_fire;

   // (t-3), (t-8), (t-14) mod 16 expressed as additions so the 4-bit index wraps naturally
   assign w_idx     = r_round_idx[3:0];
   assign w_idx_m3  = w_idx + 4'd13;
   assign w_idx_m8  = w_idx + 4'd8;
   assign w_idx_m14 = w_idx + 4'd2;
   assign w_mix     = r_buf[w_idx_m3] ^ r_buf[w_idx_m8] ^ r_buf[w_idx_m14] ^ r_buf[w_idx];
   assign w_wt      = (r_round_idx < 7'd16) ? r_buf[w_idx] : {w_mix[30:0], w_mix[31]};

   assign w_round_fire = (r_state == ST_ROUND) && !hold;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_round_idx <= 7'd0;
         r_first     <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            r_buf[i] <= 32'd0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_round_idx <= 7'd0;
               if (start) begin
                  for (int i = 0; i < 16; i++) begin
                     r_buf[i] <= block_in[511 - 32*i -: 32];
                  end
                  r_first <= first_block;
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_round_idx <= 7'd0;
               r_state     <= ST_ROUND;
            end
            ST_ROUND: begin
               if (w_round_fire) begin
                  r_buf[w_idx] <= w_wt;
                  if (r_round_idx == 7'd79) begin
                     r_state <= ST_FINISH;
                  end else begin
                     r_round_idx <= r_round_idx + 7'd1;
                  end
               end
            end
            default: begin
               r_round_idx <= 7'd0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SHA1_SEQ_BLOCK_COUNT_EN
   logic [31:0] r_block_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_block_count <= 32'd0;
      end else if (r_state == ST_FINISH) begin
         r_block_count <= r_block_count + 32'd1;
      end
   end

   assign block_count = r_block_count;
`else
   assign block_count = 32'd0;
`endif

   always_comb begin
      k_t   = K0;
      f_sel = 2'b00;
      if (r_round_idx >= 7'd60) begin
         k_t   = K3;
         f_sel = 2'b11;
      end else if (r_round_idx >= 7'd40) begin
         k_t   = K2;
         f_sel = 2'b10;
      end else if (r_round_idx >= 7'd20) begin
         k_t   = K1;
         f_sel = 2'b01;
      end
   end

   assign init_iv    = (r_state == ST_LOAD) && r_first;
   assign round_en   = w_round_fire;
   assign round_idx  = r_round_idx;
   assign w_t        = w_wt;
   assign accumulate = (r_state == ST_FINISH);
   assign done       = (r_state == ST_FINISH);
   assign busy       = (r_state != ST_IDLE);
   assign state      = r_state;

endmodule
